// File: rtl/uart_mem_host_pkg.sv
// uart_mem_host_pkg: shared states, opcodes and 8N1 frame constants for the UART memory host initiator
package uart_mem_host_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_OP,
    S_SEND_ADDR,
    S_SEND_DATA,
    S_WAIT_RSP,
    S_DONE
  } state_t;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ = 8'h52;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int BITS_PER_FRAME = 10;
endpackage

// File: rtl/uart_mem_host_phy.sv
// uart_byte_phy: 8N1 LSB-first byte serializer (gapless back-to-back) and deserializer with framing flag
module uart_byte_phy
  import uart_mem_host_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_start
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] BIT_LAST = 4'(BITS_PER_FRAME - 1);
  logic [BITS_PER_FRAME-1:0] tx_frame;
  logic [3:0] tx_bit, rx_bit;
  logic [BW-1:0] tx_baud, rx_baud;
  logic tx_act, tx_last, rx_s1, rx_s2, rx_d, rx_act, rx_tick;
  assign tx_last = tx_act && tx_bit == BIT_LAST && tx_baud == BAUD_LAST;
  assign tx_ready = !tx_act || tx_last;
  assign tx = tx_act ? tx_frame[0] : STOP_BIT;
  assign rx_tick = rx_act && rx_baud == (rx_bit == 4'd0 ? BAUD_HALF : BAUD_LAST);
  // Transmit shifter; a new byte reloads on the final stop-bit cycle so frames run without gaps
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      tx_act <= 1'b0;
      tx_frame <= '1;
      tx_bit <= '0;
      tx_baud <= '0;
    end else if (tx_valid && tx_ready) begin
      tx_act <= 1'b1;
      tx_frame <= {STOP_BIT, tx_data, START_BIT};
      tx_bit <= '0;
      tx_baud <= '0;
    end else if (tx_last) begin
      tx_act <= 1'b0;
    end else if (tx_act) begin
      tx_baud <= tx_baud == BAUD_LAST ? '0 : tx_baud + BW'(1);
      if (tx_baud == BAUD_LAST) begin
        tx_frame <= {STOP_BIT, tx_frame[BITS_PER_FRAME-1:1]};
        tx_bit <= tx_bit + 4'd1;
      end
    end
  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) {rx_s1, rx_s2, rx_d} <= 3'b111;
    else {rx_s1, rx_s2, rx_d} <= {rx, rx_s1, rx_s2};
  // Receive sequencer: start re-checked at mid-bit (glitch returns to idle), data and stop sampled at bit centres
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      rx_act <= 1'b0;
      rx_bit <= '0;
      rx_baud <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
      rx_start <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_start <= 1'b0;
      if (!rx_act) begin
        rx_act <= rx_d && !rx_s2;
        rx_bit <= '0;
        rx_baud <= '0;
      end else if (!rx_tick) begin
        rx_baud <= rx_baud + BW'(1);
      end else begin
        rx_baud <= '0;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          rx_act <= !rx_s2;
          rx_start <= !rx_s2;
        end else if (rx_bit == BIT_LAST) begin
          rx_act <= 1'b0;
          rx_valid <= 1'b1;
          rx_ferr <= rx_s2 != STOP_BIT;
        end else begin
          rx_data <= {rx_s2, rx_data[7:1]};
        end
      end
    end
endmodule

// File: rtl/uart_mem_host_initiator.sv
// uart_mem_host_initiator: turns read/write requests into UART command frames and collects read data; UART_HOST_TIMEOUT_EN adds a read-response idle timeout
module uart_mem_host_initiator
  import uart_mem_host_pkg::*;
#(
  parameter int NUM_BYTES_DATA = 4,
  parameter int NUM_BYTES_ADDRESS = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [NUM_BYTES_ADDRESS*8-1:0] req_addr,
  input  logic [NUM_BYTES_DATA*8-1:0]    req_wdata,
  output logic                           rsp_valid,
  output logic [NUM_BYTES_DATA*8-1:0]    rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  input  logic                           rx,
  output logic                           tx
);
  localparam int AW = NUM_BYTES_ADDRESS * 8;
  localparam int DW = NUM_BYTES_DATA * 8;
  localparam int MAXB = NUM_BYTES_DATA > NUM_BYTES_ADDRESS ? NUM_BYTES_DATA : NUM_BYTES_ADDRESS;
  localparam int CW = MAXB > 1 ? $clog2(MAXB) : 1;
  localparam logic [CW-1:0] LAST_A = CW'(NUM_BYTES_ADDRESS - 1);
  localparam logic [CW-1:0] LAST_D = CW'(NUM_BYTES_DATA - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, acc, acc_nx;
  logic write_q, err_q, err_nx, ready_en, timeout;
  logic [7:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_ferr, rx_start;
  assign req_ready = ready_en && state == S_IDLE;
  assign busy = state != S_IDLE;
  assign rsp_valid = state == S_DONE;
  uart_byte_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk(clk),
    .arst_n(arst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ferr(rx_ferr),
    .rx_start(rx_start)
  );
`ifdef UART_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  // Response idle timer, held clear outside WAIT_RSP and restarted by each validated start bit
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) to_cnt <= '0;
    else to_cnt <= state != S_WAIT_RSP || rx_start ? '0 : to_cnt + TW'(1);
  assign timeout = state == S_WAIT_RSP && to_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_to;
  assign timeout = 1'b0;
  assign unused_to = rx_start ^ (TIMEOUT_CYCLES > 0);
`endif
  // Next state, next byte to hand to the serializer, and read-word assembly
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    acc_nx = acc;
    err_nx = err_q;
    case (state)
      S_IDLE: begin
        tx_valid = req_valid && req_ready;
        tx_data = req_write ? OP_WRITE : OP_READ;
        acc_nx = '0;
        err_nx = 1'b0;
        cnt_nx = '0;
        if (tx_valid) state_nx = S_SEND_OP;
      end
      S_SEND_OP: begin
        tx_valid = 1'b1;
        tx_data = addr_q[7:0];
        if (tx_ready) state_nx = S_SEND_ADDR;
      end
      S_SEND_ADDR: if (tx_ready) begin
        if (cnt == LAST_A) begin
          cnt_nx = '0;
          tx_valid = write_q;
          tx_data = wdata_q[7:0];
          state_nx = write_q ? S_SEND_DATA : S_WAIT_RSP;
        end else begin
          cnt_nx = cnt + CW'(1);
          tx_valid = 1'b1;
          tx_data = addr_q[8*cnt_nx +: 8];
        end
      end
      S_SEND_DATA: if (tx_ready) begin
        if (cnt == LAST_D) begin
          cnt_nx = '0;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
          tx_valid = 1'b1;
          tx_data = wdata_q[8*cnt_nx +: 8];
        end
      end
      S_WAIT_RSP: begin
        if (rx_valid) begin
          acc_nx[8*cnt +: 8] = rx_data;
          err_nx = err_q || rx_ferr;
          cnt_nx = cnt + CW'(1);
        end
        if (timeout || (rx_valid && cnt == LAST_D)) begin
          cnt_nx = '0;
          state_nx = S_DONE;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  // State, request latches and completion registers that hold until the next completion
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      ready_en <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      acc <= '0;
      err_q <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ready_en <= 1'b1;
      acc <= acc_nx;
      err_q <= err_nx;
      if (state == S_IDLE && tx_valid) begin
        write_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state != S_DONE && state_nx == S_DONE) begin
        rsp_rdata <= write_q || timeout ? '0 : acc_nx;
        rsp_err <= timeout || err_nx;
      end
    end
endmodule

// File: doc/uart_mem_host_initiator.md
Name: uart_mem_host_initiator

Overview:
Host-side initiator for the UART memory-mapped access protocol: converts parallel read/write requests into UART command frames on tx and collects read-response bytes from rx. It sits on the host/test side of the serial link and drives the memory-mapped UART slave. It includes its own 8N1 byte serializer/deserializer and handles one outstanding request at a time.

Parameters:
NUM_BYTES_DATA, 4, data word width in bytes (rdata/wdata = NUM_BYTES_DATA*8 bits)
NUM_BYTES_ADDRESS, 1, address width in bytes
CLKS_PER_BIT, 868, clk cycles per UART bit (>=4)
TIMEOUT_CYCLES, 1000000, read-response idle timeout in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_write  input  1  1 = write, 0 = read
req_addr  input  NUM_BYTES_ADDRESS*8  target address
req_wdata  input  NUM_BYTES_DATA*8  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  NUM_BYTES_DATA*8  read data (0 for writes)
rsp_err  output  1  framing error or timeout; qualified by rsp_valid
busy  output  1  transaction in progress (~req_ready)
rx  input  1  UART serial in (asynchronous)
tx  output  1  UART serial out, idle high

Behaviour:
- Reset: tx=1, req_ready=0 for the cycle of reset release then 1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, FSM=IDLE. Reset mid-frame aborts immediately; tx goes high asynchronously.
- Frame format: opcode byte (0x57 write, 0x52 read), address bytes LSB first, then write-data bytes LSB first (writes only). Each byte is 8N1 LSB-first: 1 start bit (0), 8 data bits, 1 stop bit (1), each CLKS_PER_BIT cycles. Bytes are sent back-to-back with no idle gap.
- Handshake: accept on req_valid & req_ready; addr/wdata/write are latched. req_ready drops the next cycle. Requests are not queued.
- FSM: IDLE -> SEND_OP -> SEND_ADDR (NUM_BYTES_ADDRESS bytes) -> SEND_DATA (write, NUM_BYTES_DATA bytes) or WAIT_RSP (read) -> DONE -> IDLE.
- The first start bit drives tx the cycle after acceptance.
- Write: DONE is entered after the last stop bit completes. rsp_valid pulses 1 cycle with rsp_rdata=0 and rsp_err=0.
- Read, WAIT_RSP: receive NUM_BYTES_DATA bytes, assembled LSB first.
  - After the last stop bit is sampled: rsp_valid pulses with the assembled word.
  - A stop bit sampled 0 still counts the byte and sets a sticky error; rsp_err=1 on completion.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata/rsp_err hold until the next completion.
- The next request may be accepted the cycle after the rsp_valid pulse (IDLE, req_ready=1).
- RX path:
  - rx passes through a 2-flop synchronizer.
  - A start is detected on a falling edge and validated at mid-bit (CLKS_PER_BIT/2); a glitch returns the receiver to idle.
  - Data is sampled at bit centres.
  - Bytes arriving outside WAIT_RSP are discarded.
- Counters: bit counter 0..9, baud counter 0..CLKS_PER_BIT-1, byte counter sized to max(NUM_BYTES_DATA, NUM_BYTES_ADDRESS). All wrap to 0 on byte or state change.

Optional Feature:
UART_HOST_TIMEOUT_EN.
- Defined: in WAIT_RSP, a counter resets on each validated start bit and on entry to WAIT_RSP. On reaching TIMEOUT_CYCLES it forces DONE: rsp_valid=1, rsp_err=1, rsp_rdata=0. Any in-progress RX byte is abandoned.
- Undefined: no counter is present; WAIT_RSP waits indefinitely (only reset exits).

Decomposition:
- Package uart_mem_host_pkg:
  - state enum typedef
  - opcode constants OP_WRITE=8'h57, OP_READ=8'h52
  - UART frame constants (start, stop, bits per frame = 10)
- Sub-module uart_byte_phy: 8N1 tx serializer and rx deserializer.
  - TX: byte in / valid / ready.
  - RX: byte valid pulse + framing-error flag.
  - Parameterised by CLKS_PER_BIT; instantiated once.

Test Plan:
- CLKS_PER_BIT=4, write addr 0x10 data 0xDEADBEEF -> tx bytes 0x57,0x10,0xEF,0xBE,0xAD,0xDE back-to-back; rsp_valid 1 cycle about 240 cycles after acceptance, rsp_err=0, rsp_rdata=0.
- Read addr 0x20; bench drives rx 0x78,0x56,0x34,0x12 after the tx address byte -> tx 0x52,0x20; rsp_valid with rsp_rdata=0x12345678, rsp_err=0.
- Second req_valid held during a transaction -> req_ready=0, no second frame; accepted the cycle after rsp_valid.
- Read response with stop bit 0 on byte 2 -> 4 bytes consumed, rsp_err=1. A 1-cycle rx glitch in IDLE -> ignored, no byte counted.
- UART_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100: read with no rx activity -> rsp_valid, rsp_err=1, rsp_rdata=0 about 100 cycles after the last tx stop bit.
- arst_n asserted mid address byte -> tx=1 immediately, req_ready=1 after release, next write frame transmits correctly.
